// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: a registered 33x33 multiply and a
// 32-step restoring divider behind a one-in-flight valid/ready handshake.
module muldiv_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [2:0]  funct3_q;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] rem_q;
  logic [4:0]  count;
  logic        quot_neg;
  logic        rem_neg;

  logic        accept;
  logic        req_is_div;
  logic        req_signed;
  logic        div_by_zero;
  logic        div_ovf;
  logic        div_special;
  logic [31:0] special_result;
  logic [31:0] rs1_abs;
  logic [31:0] rs2_abs;

  logic               mul_a_signed;
  logic               mul_b_signed;
  logic signed [32:0] mul_a_ext;
  logic signed [32:0] mul_b_ext;
  logic signed [63:0] product;

  logic [32:0] partial;
  logic [32:0] trial;
  logic        quot_bit;
  logic [31:0] step_rem;
  logic [31:0] fix_quot;
  logic [31:0] fix_rem;

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_DONE);

  assign accept      = req_valid & req_ready & ~flush;
  assign req_is_div  = req_funct3[2];
  assign req_signed  = ~req_funct3[0];
  assign div_by_zero = (req_rs2 == 32'h0);
  assign div_ovf     = req_signed & (req_rs1 == 32'h8000_0000) & (req_rs2 == 32'hFFFF_FFFF);
  assign div_special = div_by_zero | div_ovf;

  assign rs1_abs = (req_signed & req_rs1[31]) ? (~req_rs1 + 32'd1) : req_rs1;
  assign rs2_abs = (req_signed & req_rs2[31]) ? (~req_rs2 + 32'd1) : req_rs2;

  // Special-case divide results are known at accept and skip the iterations.
  always_comb begin
    special_result = 32'hFFFF_FFFF;
    if (req_funct3[1]) begin
      special_result = div_by_zero ? req_rs1 : 32'h0;
    end else if (!div_by_zero) begin
      special_result = 32'h8000_0000;
    end
  end

  // Operand extension: mul/mulh signed x signed, mulhsu signed x unsigned, mulhu unsigned.
  assign mul_a_signed = (funct3_q[1:0] != 2'b11);
  assign mul_b_signed = ~funct3_q[1];
  assign mul_a_ext    = $signed({mul_a_signed & op_a[31], op_a});
  assign mul_b_ext    = $signed({mul_b_signed & op_b[31], op_b});
  assign product      = mul_a_ext * mul_b_ext;

  // One restoring step: op_a shifts out dividend bits and collects quotient bits.
  assign partial  = {rem_q, op_a[31]};
  assign trial    = partial - {1'b0, op_b};
  assign quot_bit = ~trial[32];
  assign step_rem = quot_bit ? trial[31:0] : partial[31:0];

  assign fix_quot = quot_neg ? (~op_a + 32'd1) : op_a;
  assign fix_rem  = rem_neg ? (~rem_q + 32'd1) : rem_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!req_is_div) begin
              state_next = S_MUL;
            end else if (div_special) begin
              state_next = S_DONE;
            end else begin
              state_next = S_DIV;
            end
          end
        end
        S_MUL:   state_next = S_DONE;
        S_DIV:   if (count == 5'd31) state_next = S_FIX;
        S_FIX:   state_next = S_DONE;
        S_DONE:  if (resp_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath is frozen under flush so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      funct3_q  <= 3'b0;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      rem_q     <= 32'h0;
      count     <= 5'd0;
      quot_neg  <= 1'b0;
      rem_neg   <= 1'b0;
      resp_data <= 32'h0;
      resp_tag  <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            funct3_q <= req_funct3;
            resp_tag <= req_tag;
            count    <= 5'd0;
            rem_q    <= 32'h0;
            if (!req_is_div) begin
              op_a <= req_rs1;
              op_b <= req_rs2;
            end else if (div_special) begin
              resp_data <= special_result;
            end else begin
              op_a     <= rs1_abs;
              op_b     <= rs2_abs;
              quot_neg <= req_signed & (req_rs1[31] ^ req_rs2[31]);
              rem_neg  <= req_signed & req_rs1[31];
            end
          end
        end
        S_MUL: begin
          resp_data <= (funct3_q[1:0] == 2'b00) ? product[31:0] : product[63:32];
        end
        S_DIV: begin
          rem_q <= step_rem;
          op_a  <= {op_a[30:0], quot_bit};
          count <= count + 5'd1;
        end
        S_FIX: begin
          resp_data <= funct3_q[1] ? fix_rem : fix_quot;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
